alu_op_sequencer: RTL and testbench

// - Initiator side of the 32-bit arithmetic unit (ADD/SUB/SLT, 4-bit select).
// - Accepts R-type commands (funct, a, b) over valid/ready and decodes funct to the ALU select code.
// - Drives registered operands, waits a settle time, captures the ALU result and returns it over a valid/ready response channel.
// - Sits between the decode stage and the combinational arithmetic unit.

---
 rtl/alu_op_sequencer_if.sv | 31 +++
 rtl/alu_op_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// Command, arithmetic-unit and response signals of the ALU operation sequencer.
// slave is the sequencer's view; master is the surrounding environment's view.
interface alu_op_sequencer_if #(parameter int CNT_W = 16);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [5:0]       cmd_funct;
  logic [31:0]      cmd_a;
  logic [31:0]      cmd_b;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [3:0]       alu_select;
  logic [31:0]      alu_result;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic             rsp_err;
  logic             rsp_zero;
  logic [CNT_W-1:0] op_count;

  modport slave (
    input  cmd_valid, cmd_funct, cmd_a, cmd_b, alu_result, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_select, rsp_valid, rsp_data, rsp_err,
           rsp_zero, op_count
  );

  modport master (
    output cmd_valid, cmd_funct, cmd_a, cmd_b, alu_result, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_select, rsp_valid, rsp_data, rsp_err,
           rsp_zero, op_count
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issues decoded R-type operations to a combinational ALU and returns the settled result.
// ALU_SEQ_RSP_FIFO_EN replaces the single response register/RESP state with a 2-entry FIFO.
//
// state | meaning
// IDLE  | ready for a command
// WAIT  | operands driven, settle counter running (illegal funct waits one cycle)
// RESP  | response held until handoff (single-register build only)
module alu_op_sequencer #(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 16
) (
  input logic               clk,
  input logic               rst_n,
  alu_op_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [3:0]       settle_cnt;
  logic             err_pend;
  logic [31:0]      alu_a_q, alu_b_q;
  logic [3:0]       alu_sel_q;
  logic [CNT_W-1:0] op_cnt_q;

  logic             funct_legal;
  logic [3:0]       funct_sel;
  logic             accept, capture;
  logic             cmd_ready_c, rsp_valid_c;
  logic [31:0]      cap_data;
  logic             cap_err;
  logic [31:0]      rsp_data_c;
  logic             rsp_err_c;

`ifdef ALU_SEQ_RSP_FIFO_EN
  logic [31:0]      fifo_data [2];
  logic             fifo_err  [2];
  logic             wr_ptr, rd_ptr;
  logic [1:0]       fifo_cnt;
  logic             pop;
`else
  logic [31:0]      rsp_data_q;
  logic             rsp_err_q;
  logic             handoff;
`endif

  always_comb begin
    funct_legal = 1'b1;
    funct_sel   = 4'b0000;
    case (bus.cmd_funct)
      6'b100000: funct_sel = 4'b0000;
      6'b100010: funct_sel = 4'b0010;
      6'b101010: funct_sel = 4'b1010;
      default:   funct_legal = 1'b0;
    endcase
  end

  // An illegal funct rides the WAIT path for one cycle and captures an error entry.
  assign cap_data = err_pend ? 32'd0 : bus.alu_result;
  assign cap_err  = err_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d     = state;
    cmd_ready_c = 1'b0;
    accept      = 1'b0;
    capture     = 1'b0;
    case (state)
      IDLE: begin
`ifdef ALU_SEQ_RSP_FIFO_EN
        cmd_ready_c = (fifo_cnt != 2'd2);
`else
        cmd_ready_c = 1'b1;
`endif
        if (bus.cmd_valid && cmd_ready_c) begin
          accept  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (settle_cnt == 4'd1) begin
          capture = 1'b1;
`ifdef ALU_SEQ_RSP_FIFO_EN
          state_d = IDLE;
`else
          state_d = RESP;
`endif
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q    <= 32'd0;
      alu_b_q    <= 32'd0;
      alu_sel_q  <= 4'b0000;
      settle_cnt <= 4'd0;
      err_pend   <= 1'b0;
    end else if (accept) begin
      if (funct_legal) begin
        alu_a_q    <= bus.cmd_a;
        alu_b_q    <= bus.cmd_b;
        alu_sel_q  <= funct_sel;
        settle_cnt <= 4'(SETTLE_CYCLES);
        err_pend   <= 1'b0;
      end else begin
        settle_cnt <= 4'd1;
        err_pend   <= 1'b1;
      end
    end else if (state == WAIT) begin
      settle_cnt <= settle_cnt - 4'd1;
    end
  end

`ifdef ALU_SEQ_RSP_FIFO_EN
  assign rsp_valid_c = (fifo_cnt != 2'd0);
  assign rsp_data_c  = fifo_data[rd_ptr];
  assign rsp_err_c   = fifo_err[rd_ptr];
  assign pop         = rsp_valid_c && bus.rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= 32'd0;
        fifo_err[i]  <= 1'b0;
      end
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
      op_cnt_q <= '0;
    end else begin
      if (capture) begin
        fifo_data[wr_ptr] <= cap_data;
        fifo_err[wr_ptr]  <= cap_err;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        if (!fifo_err[rd_ptr]) op_cnt_q <= op_cnt_q + CNT_W'(1);
      end
      case ({capture, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end
`else
  assign rsp_valid_c = (state == RESP);
  assign rsp_data_c  = rsp_data_q;
  assign rsp_err_c   = rsp_err_q;
  assign handoff     = rsp_valid_c && bus.rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data_q <= 32'd0;
      rsp_err_q  <= 1'b0;
      op_cnt_q   <= '0;
    end else begin
      if (capture) begin
        rsp_data_q <= cap_data;
        rsp_err_q  <= cap_err;
      end
      if (handoff && !rsp_err_q) op_cnt_q <= op_cnt_q + CNT_W'(1);
    end
  end
`endif

  assign bus.cmd_ready  = cmd_ready_c;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_select = alu_sel_q;
  assign bus.rsp_valid  = rsp_valid_c;
  assign bus.rsp_data   = rsp_data_c;
  assign bus.rsp_err    = rsp_err_c;
  assign bus.rsp_zero   = (rsp_data_c == 32'd0);
  assign bus.op_count   = op_cnt_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench: dut1 uses SETTLE_CYCLES=1, dut3 uses SETTLE_CYCLES=3, both with a stub ALU.
module tb_alu_op_sequencer;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  alu_op_sequencer_if #(.CNT_W(16)) bus1 ();
  alu_op_sequencer_if #(.CNT_W(16)) bus3 ();

  alu_op_sequencer #(.SETTLE_CYCLES(1), .CNT_W(16)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  alu_op_sequencer #(.SETTLE_CYCLES(3), .CNT_W(16)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  function automatic logic [31:0] stub_alu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] sel);
    case (sel)
      4'b0000: return a + b;
      4'b0010: return a - b;
      4'b1010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign bus1.alu_result = stub_alu(bus1.alu_a, bus1.alu_b, bus1.alu_select);
  assign bus3.alu_result = stub_alu(bus3.alu_a, bus3.alu_b, bus3.alu_select);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // One SETTLE_CYCLES=1 transaction on dut1 with rsp_ready held high.
  task automatic op1(input string nm, input logic [5:0] f, input logic [31:0] a,
                     input logic [31:0] b, input logic [3:0] exp_sel,
                     input logic [31:0] exp_a, input logic [31:0] exp_data,
                     input logic exp_err, input logic [15:0] exp_cnt);
    logic exp_rdy_resp;
`ifdef ALU_SEQ_RSP_FIFO_EN
    exp_rdy_resp = 1'b1;
`else
    exp_rdy_resp = 1'b0;
`endif
    bus1.cmd_funct = f; bus1.cmd_a = a; bus1.cmd_b = b;
    bus1.cmd_valid = 1'b1; bus1.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus1.cmd_valid = 1'b0;
    checks++; if (bus1.alu_select !== exp_sel) begin failures++; $display("FAIL %s alu_select got=%h exp=%h", nm, bus1.alu_select, exp_sel); end
    checks++; if (bus1.alu_a !== exp_a) begin failures++; $display("FAIL %s alu_a got=%h exp=%h", nm, bus1.alu_a, exp_a); end
    checks++; if (bus1.rsp_valid !== 1'b0) begin failures++; $display("FAIL %s early_rsp_valid got=%b exp=0", nm, bus1.rsp_valid); end
    checks++; if (bus1.cmd_ready !== 1'b0) begin failures++; $display("FAIL %s wait_cmd_ready got=%b exp=0", nm, bus1.cmd_ready); end
    @(posedge clk); #1;
    checks++; if (bus1.rsp_valid !== 1'b1) begin failures++; $display("FAIL %s rsp_valid got=%b exp=1", nm, bus1.rsp_valid); end
    checks++; if (bus1.rsp_data !== exp_data) begin failures++; $display("FAIL %s rsp_data got=%h exp=%h", nm, bus1.rsp_data, exp_data); end
    checks++; if (bus1.rsp_err !== exp_err) begin failures++; $display("FAIL %s rsp_err got=%b exp=%b", nm, bus1.rsp_err, exp_err); end
    checks++; if (bus1.rsp_zero !== (exp_data == 32'd0)) begin failures++; $display("FAIL %s rsp_zero got=%b exp=%b", nm, bus1.rsp_zero, exp_data == 32'd0); end
    checks++; if (bus1.cmd_ready !== exp_rdy_resp) begin failures++; $display("FAIL %s resp_cmd_ready got=%b exp=%b", nm, bus1.cmd_ready, exp_rdy_resp); end
    @(posedge clk); #1;
    checks++; if (bus1.rsp_valid !== 1'b0) begin failures++; $display("FAIL %s post_rsp_valid got=%b exp=0", nm, bus1.rsp_valid); end
    checks++; if (bus1.cmd_ready !== 1'b1) begin failures++; $display("FAIL %s post_cmd_ready got=%b exp=1", nm, bus1.cmd_ready); end
    checks++; if (bus1.op_count !== exp_cnt) begin failures++; $display("FAIL %s op_count got=%0d exp=%0d", nm, bus1.op_count, exp_cnt); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus1.cmd_ready !== 1'b1) begin failures++; $display("FAIL reset cmd_ready got=%b exp=1", bus1.cmd_ready); end
    checks++; if (bus1.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset rsp_valid got=%b exp=0", bus1.rsp_valid); end
    checks++; if (bus1.rsp_data !== 32'd0) begin failures++; $display("FAIL reset rsp_data got=%h exp=0", bus1.rsp_data); end
    checks++; if (bus1.rsp_zero !== 1'b1) begin failures++; $display("FAIL reset rsp_zero got=%b exp=1", bus1.rsp_zero); end
    checks++; if (bus1.rsp_err !== 1'b0) begin failures++; $display("FAIL reset rsp_err got=%b exp=0", bus1.rsp_err); end
    checks++; if (bus1.op_count !== 16'd0) begin failures++; $display("FAIL reset op_count got=%0d exp=0", bus1.op_count); end
    checks++; if (bus1.alu_select !== 4'b0000) begin failures++; $display("FAIL reset alu_select got=%h exp=0", bus1.alu_select); end
    checks++; if (bus1.alu_a !== 32'd0 || bus1.alu_b !== 32'd0) begin failures++; $display("FAIL reset alu_ab got=%h/%h exp=0/0", bus1.alu_a, bus1.alu_b); end
    checks++; if (bus3.cmd_ready !== 1'b1) begin failures++; $display("FAIL reset3 cmd_ready got=%b exp=1", bus3.cmd_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_ops();
    op1("add",     6'b100000, 32'd5,        32'd7, 4'b0000, 32'd5,        32'd12, 1'b0, 16'd1);
    op1("sub",     6'b100010, 32'd3,        32'd3, 4'b0010, 32'd3,        32'd0,  1'b0, 16'd2);
    op1("slt",     6'b101010, 32'hFFFFFFFF, 32'd1, 4'b1010, 32'hFFFFFFFF, 32'd1,  1'b0, 16'd3);
    op1("slt0",    6'b101010, 32'd5,        32'd2, 4'b1010, 32'd5,        32'd0,  1'b0, 16'd4);
    op1("illegal", 6'b100100, 32'd9,        32'd9, 4'b1010, 32'd5,        32'd0,  1'b1, 16'd4);
  endtask

`ifndef ALU_SEQ_RSP_FIFO_EN
  task automatic test_stall();
    bus3.rsp_ready = 1'b0;
    bus3.cmd_funct = 6'b100000; bus3.cmd_a = 32'd10; bus3.cmd_b = 32'd20;
    bus3.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus3.cmd_valid = 1'b0;
    checks++; if (bus3.alu_a !== 32'd10) begin failures++; $display("FAIL stall alu_a got=%h exp=a", bus3.alu_a); end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++; if (bus3.rsp_valid !== 1'b0) begin failures++; $display("FAIL stall early_valid%0d got=%b exp=0", i, bus3.rsp_valid); end
    end
    @(posedge clk); #1;
    checks++; if (bus3.rsp_valid !== 1'b1) begin failures++; $display("FAIL stall rsp_valid got=%b exp=1", bus3.rsp_valid); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (bus3.rsp_valid !== 1'b1 || bus3.rsp_data !== 32'd30) begin failures++; $display("FAIL stall hold%0d got=%b/%0d exp=1/30", i, bus3.rsp_valid, bus3.rsp_data); end
      checks++; if (bus3.cmd_ready !== 1'b0) begin failures++; $display("FAIL stall cmd_ready%0d got=%b exp=0", i, bus3.cmd_ready); end
    end
    bus3.rsp_ready = 1'b1;
    bus3.cmd_funct = 6'b100010; bus3.cmd_a = 32'd50; bus3.cmd_b = 32'd8;
    bus3.cmd_valid = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus3.alu_select !== 4'b0000) begin failures++; $display("FAIL stall handoff_accept got=%h exp=0", bus3.alu_select); end
    checks++; if (bus3.cmd_ready !== 1'b1 || bus3.rsp_valid !== 1'b0) begin failures++; $display("FAIL stall after_handoff got=%b/%b exp=1/0", bus3.cmd_ready, bus3.rsp_valid); end
    checks++; if (bus3.op_count !== 16'd1) begin failures++; $display("FAIL stall op_count got=%0d exp=1", bus3.op_count); end
    @(posedge clk); #1;
    bus3.cmd_valid = 1'b0;
    checks++; if (bus3.alu_select !== 4'b0010 || bus3.alu_a !== 32'd50) begin failures++; $display("FAIL stall second_issue got=%h/%h exp=2/32", bus3.alu_select, bus3.alu_a); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus3.rsp_valid !== 1'b1 || bus3.rsp_data !== 32'd42) begin failures++; $display("FAIL stall second_rsp got=%b/%0d exp=1/42", bus3.rsp_valid, bus3.rsp_data); end
    @(posedge clk); #1;
    checks++; if (bus3.op_count !== 16'd2) begin failures++; $display("FAIL stall op_count2 got=%0d exp=2", bus3.op_count); end
  endtask
`else
  task automatic test_fifo();
    bus3.rsp_ready = 1'b0;
    bus3.cmd_funct = 6'b100000; bus3.cmd_a = 32'd1; bus3.cmd_b = 32'd1;
    bus3.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus3.cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus3.rsp_valid !== 1'b1 || bus3.rsp_data !== 32'd2) begin failures++; $display("FAIL fifo first got=%b/%0d exp=1/2", bus3.rsp_valid, bus3.rsp_data); end
    checks++; if (bus3.cmd_ready !== 1'b1) begin failures++; $display("FAIL fifo ready1 got=%b exp=1", bus3.cmd_ready); end
    bus3.cmd_a = 32'd2; bus3.cmd_b = 32'd2; bus3.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus3.cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus3.cmd_ready !== 1'b0) begin failures++; $display("FAIL fifo full_ready got=%b exp=0", bus3.cmd_ready); end
    checks++; if (bus3.rsp_data !== 32'd2) begin failures++; $display("FAIL fifo head got=%0d exp=2", bus3.rsp_data); end
    bus3.cmd_a = 32'd3; bus3.cmd_b = 32'd3; bus3.cmd_valid = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus3.cmd_ready !== 1'b0 || bus3.alu_a !== 32'd2) begin failures++; $display("FAIL fifo blocked got=%b/%0d exp=0/2", bus3.cmd_ready, bus3.alu_a); end
    bus3.rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus3.rsp_data !== 32'd4 || bus3.op_count !== 16'd1) begin failures++; $display("FAIL fifo pop1 got=%0d/%0d exp=4/1", bus3.rsp_data, bus3.op_count); end
    checks++; if (bus3.cmd_ready !== 1'b1) begin failures++; $display("FAIL fifo ready2 got=%b exp=1", bus3.cmd_ready); end
    @(posedge clk); #1;
    bus3.cmd_valid = 1'b0;
    checks++; if (bus3.alu_a !== 32'd3 || bus3.rsp_valid !== 1'b0 || bus3.op_count !== 16'd2) begin failures++; $display("FAIL fifo third got=%0d/%b/%0d exp=3/0/2", bus3.alu_a, bus3.rsp_valid, bus3.op_count); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus3.rsp_valid !== 1'b1 || bus3.rsp_data !== 32'd6) begin failures++; $display("FAIL fifo third_rsp got=%b/%0d exp=1/6", bus3.rsp_valid, bus3.rsp_data); end
    @(posedge clk); #1;
    checks++; if (bus3.op_count !== 16'd3) begin failures++; $display("FAIL fifo op_count got=%0d exp=3", bus3.op_count); end
  endtask
`endif

  task automatic test_reset_mid();
    bus1.cmd_funct = 6'b100000; bus1.cmd_a = 32'd1; bus1.cmd_b = 32'd2;
    bus1.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus1.cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (bus1.cmd_ready !== 1'b1) begin failures++; $display("FAIL rstmid cmd_ready got=%b exp=1", bus1.cmd_ready); end
    checks++; if (bus1.alu_a !== 32'd0 || bus1.alu_select !== 4'b0000) begin failures++; $display("FAIL rstmid alu got=%h/%h exp=0/0", bus1.alu_a, bus1.alu_select); end
    checks++; if (bus1.op_count !== 16'd0 || bus1.rsp_zero !== 1'b1) begin failures++; $display("FAIL rstmid count_zero got=%0d/%b exp=0/1", bus1.op_count, bus1.rsp_zero); end
    @(posedge clk); #1;
    checks++; if (bus1.rsp_valid !== 1'b0) begin failures++; $display("FAIL rstmid rsp_valid got=%b exp=0", bus1.rsp_valid); end
    rst_n = 1'b1;
    op1("recover", 6'b100000, 32'd100, 32'd23, 4'b0000, 32'd100, 32'd123, 1'b0, 16'd1);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0;
    bus1.cmd_valid = 1'b0; bus1.cmd_funct = 6'd0; bus1.cmd_a = 32'd0; bus1.cmd_b = 32'd0; bus1.rsp_ready = 1'b1;
    bus3.cmd_valid = 1'b0; bus3.cmd_funct = 6'd0; bus3.cmd_a = 32'd0; bus3.cmd_b = 32'd0; bus3.rsp_ready = 1'b0;
    test_reset();
    test_ops();
`ifdef ALU_SEQ_RSP_FIFO_EN
    test_fifo();
`else
    test_stall();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
